// File: rtl/max_pool_reader_2x2.sv
// max_pool_reader_2x2
// ---------------------------------------------------------------------------
// Reads a finished NUM_MULT-lane feature map out of the upstream conv/ReLU
// result memories and produces a 2x2, stride-2, signed max pool. Port A reads
// the even input row of each window and port B the odd row. Each output pixel
// takes two issue cycles: the left column, then the right column. One pooled
// word is emitted every second cycle, tagged with its output index.
//
// Ports
//   clock, reset             single rising-edge clock, async active-high reset
//   start                    one-cycle pulse (upstream done); accepted in IDLE only
//   address_a/b_t_use_out    upstream read addresses (A: even rows, B: odd rows)
//   rden_a/b_use_out         upstream read enables
//   wren_a/b_use_out         tied to 0; this block never writes upstream
//   q_a_all_in, q_b_all_in   upstream read data, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   pool_data_all            pooled word, same lane packing
//   pool_valid, pool_addr    single-cycle strobe and output index pr*(IN_COLS/2)+pc
//   busy, done               busy while a map is processed; done pulses once at the end
//
// Optional feature: define POOL_RELU_CLAMP_EN to clamp negative pooled lanes
// to 0 at the same latency. Without it, the signed max passes through as-is.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module max_pool_reader_2x2 #(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_MULT        = 4,
  parameter int POOL_ADDR_WIDTH = 10,
  parameter int OUT_ADDR_WIDTH  = 8,
  parameter int IN_ROWS         = 24,
  parameter int IN_COLS         = 24,
  parameter int RD_LATENCY      = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           start,
  output logic [POOL_ADDR_WIDTH-1:0]     address_a_t_use_out,
  output logic [POOL_ADDR_WIDTH-1:0]     address_b_t_use_out,
  output logic                           rden_a_use_out,
  output logic                           rden_b_use_out,
  output logic                           wren_a_use_out,
  output logic                           wren_b_use_out,
  input  logic [DATA_WIDTH*NUM_MULT-1:0] q_a_all_in,
  input  logic [DATA_WIDTH*NUM_MULT-1:0] q_b_all_in,
  output logic [DATA_WIDTH*NUM_MULT-1:0] pool_data_all,
  output logic                           pool_valid,
  output logic [OUT_ADDR_WIDTH-1:0]      pool_addr,
  output logic                           busy,
  output logic                           done
);

  localparam int LW       = DATA_WIDTH * NUM_MULT;
  localparam int OUT_ROWS = IN_ROWS / 2;
  localparam int OUT_COLS = IN_COLS / 2;
  localparam int PR_W     = (OUT_ROWS > 1) ? $clog2(OUT_ROWS) : 1;
  localparam int PC_W     = (OUT_COLS > 1) ? $clog2(OUT_COLS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  state_t                      state_q, state_d;
  logic [PR_W-1:0]             pr_q, pr_d;
  logic [PC_W-1:0]             pc_q, pc_d;
  logic                        phase_q, phase_d;
  logic [POOL_ADDR_WIDTH-1:0]  addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic                        rden_q, rden_d;
  logic                        issue_ph_q, issue_ph_d;   // phase of the read issued this cycle
  logic [RD_LATENCY-1:0]       vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0]       ph_pipe_q, ph_pipe_d;
  logic [LW-1:0]               m0_q, m0_d;
  logic [LW-1:0]               pool_data_q, pool_data_d;
  logic                        pool_valid_q, pool_valid_d;
  logic [OUT_ADDR_WIDTH-1:0]   pool_addr_q, pool_addr_d;
  logic [OUT_ADDR_WIDTH-1:0]   out_cnt_q, out_cnt_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        out_clr;
  logic                        tap_vld, tap_ph, pipe_empty;
  logic [LW-1:0]               ab_max_all, pool_lane_all;

  // Returned data lines up with the last stage of the valid/phase pipeline.
  assign tap_vld    = vld_pipe_q[RD_LATENCY-1];
  assign tap_ph     = ph_pipe_q[RD_LATENCY-1];
  assign pipe_empty = !rden_q && (vld_pipe_q == '0);

  // Per-lane signed compare network.
  for (genvar gi = 0; gi < NUM_MULT; gi++) begin : g_lane
    logic signed [DATA_WIDTH-1:0] a_l, b_l, ab_max, m0_l, fin_max, fin_l;
    assign a_l     = q_a_all_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign b_l     = q_b_all_in[gi*DATA_WIDTH +: DATA_WIDTH];
    assign m0_l    = m0_q[gi*DATA_WIDTH +: DATA_WIDTH];
    assign ab_max  = (a_l > b_l) ? a_l : b_l;
    assign fin_max = (m0_l > ab_max) ? m0_l : ab_max;
`ifdef POOL_RELU_CLAMP_EN
    assign fin_l   = fin_max[DATA_WIDTH-1] ? '0 : fin_max;
`else
    assign fin_l   = fin_max;
`endif
    assign ab_max_all[gi*DATA_WIDTH +: DATA_WIDTH]    = ab_max;
    assign pool_lane_all[gi*DATA_WIDTH +: DATA_WIDTH] = fin_l;
  end

  // Control FSM: read issue, address generation and handshake outputs.
  always_comb begin
    state_d    = state_q;
    pr_d       = pr_q;
    pc_d       = pc_q;
    phase_d    = phase_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    rden_d     = 1'b0;
    issue_ph_d = issue_ph_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    out_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_READ;
          pr_d    = '0;
          pc_d    = '0;
          phase_d = 1'b0;
          busy_d  = 1'b1;
          out_clr = 1'b1;
        end
      end
      ST_READ: begin
        // Column offset is the phase: left column first, right column second.
        addr_a_d   = POOL_ADDR_WIDTH'((2 * int'(pr_q)) * IN_COLS + 2 * int'(pc_q) + int'(phase_q));
        addr_b_d   = POOL_ADDR_WIDTH'((2 * int'(pr_q) + 1) * IN_COLS + 2 * int'(pc_q) + int'(phase_q));
        rden_d     = 1'b1;
        issue_ph_d = phase_q;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (pc_q == PC_W'(OUT_COLS - 1)) begin
            pc_d = '0;
            if (pr_q == PR_W'(OUT_ROWS - 1)) state_d = ST_DRAIN;
            else                             pr_d    = pr_q + PR_W'(1);
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Reaching empty means the last pool_valid is on the output this cycle.
        if (pipe_empty) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Return pipeline: the phase-0 pair max is parked in m0, then merged with the phase-1 pair.
  always_comb begin
    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = rden_q;
    ph_pipe_d     = ph_pipe_q << 1;
    ph_pipe_d[0]  = issue_ph_q;
    m0_d          = m0_q;
    pool_valid_d  = 1'b0;
    pool_data_d   = pool_data_q;
    pool_addr_d   = pool_addr_q;
    out_cnt_d     = out_clr ? '0 : out_cnt_q;
    if (tap_vld && !tap_ph) m0_d = ab_max_all;
    if (tap_vld && tap_ph) begin
      pool_valid_d = 1'b1;
      pool_data_d  = pool_lane_all;
      pool_addr_d  = out_cnt_q;
      out_cnt_d    = out_cnt_q + OUT_ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pr_q         <= '0;
      pc_q         <= '0;
      phase_q      <= 1'b0;
      addr_a_q     <= '0;
      addr_b_q     <= '0;
      rden_q       <= 1'b0;
      issue_ph_q   <= 1'b0;
      vld_pipe_q   <= '0;
      ph_pipe_q    <= '0;
      m0_q         <= '0;
      pool_data_q  <= '0;
      pool_valid_q <= 1'b0;
      pool_addr_q  <= '0;
      out_cnt_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      phase_q      <= phase_d;
      addr_a_q     <= addr_a_d;
      addr_b_q     <= addr_b_d;
      rden_q       <= rden_d;
      issue_ph_q   <= issue_ph_d;
      vld_pipe_q   <= vld_pipe_d;
      ph_pipe_q    <= ph_pipe_d;
      m0_q         <= m0_d;
      pool_data_q  <= pool_data_d;
      pool_valid_q <= pool_valid_d;
      pool_addr_q  <= pool_addr_d;
      out_cnt_q    <= out_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign address_a_t_use_out = addr_a_q;
  assign address_b_t_use_out = addr_b_q;
  assign rden_a_use_out      = rden_q;
  assign rden_b_use_out      = rden_q;
  assign wren_a_use_out      = 1'b0;
  assign wren_b_use_out      = 1'b0;
  assign pool_data_all       = pool_data_q;
  assign pool_valid          = pool_valid_q;
  assign pool_addr           = pool_addr_q;
  assign busy                = busy_q;
  assign done                = done_q;

endmodule

// File: doc/max_pool_reader_2x2.md
Name: max_pool_reader_2x2

Overview:
- Downstream neighbour of the conv/ReLU layer stage. Consumes that stage's per-channel result memories through their "use" port set.
- After the upstream layer pulses its done flag, this block reads each NUM_MULT-lane feature map and computes a 2x2 stride-2 signed max pool.
- Emits one pooled NUM_MULT-lane word every two cycles, with an output address, to the next layer's input buffer.
- Read-only master of the upstream memories: write enables are held at 0.

Parameters:
- DATA_WIDTH, 8, width of one feature element (signed two's complement).
- NUM_MULT, 4, number of parallel channels (lanes) per memory word.
- POOL_ADDR_WIDTH, 10, upstream memory address width.
- OUT_ADDR_WIDTH, 8, output address width.
- IN_ROWS, 24, input map rows; must be even and >= 2.
- IN_COLS, 24, input map columns; must be even and >= 2.
- RD_LATENCY, 2, cycles from address/rden to valid q on the upstream memory (1..3).

Ports:
- clock, in, 1, single clock; all logic on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle pulse; connected to the upstream done flag.
- address_a_t_use_out, out, POOL_ADDR_WIDTH, port A read address; addresses even rows.
- address_b_t_use_out, out, POOL_ADDR_WIDTH, port B read address; addresses odd rows.
- rden_a_use_out, out, 1, port A read enable.
- rden_b_use_out, out, 1, port B read enable.
- wren_a_use_out, out, 1, constant 0.
- wren_b_use_out, out, 1, constant 0.
- q_a_all_in, in, DATA_WIDTH*NUM_MULT, port A read data; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- q_b_all_in, in, DATA_WIDTH*NUM_MULT, port B read data; same lane packing.
- pool_data_all, out, DATA_WIDTH*NUM_MULT, pooled word; same lane packing.
- pool_valid, out, 1, pool_data_all and pool_addr valid this cycle.
- pool_addr, out, OUT_ADDR_WIDTH, output index pr*(IN_COLS/2)+pc.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the whole map has been emitted.

Behaviour:
- Reset (async): FSM to IDLE; all counters, pipeline valids and every output register to 0. This includes addresses, rden, pool_data_all, pool_valid, pool_addr, busy and done.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE: on start go to READ and clear pr, pc and phase. start is ignored in all other states.
  - READ: per output pixel (pr, pc), two issue cycles.
    - phase 0: addr_a = (2pr)*IN_COLS + 2pc; addr_b = (2pr+1)*IN_COLS + 2pc.
    - phase 1: same rows, column 2pc+1.
    - rden_a and rden_b are high in both phases.
    - After the phase 1 issue of pixel (IN_ROWS/2-1, IN_COLS/2-1), go to DRAIN.
    - pc wraps at IN_COLS/2 and increments pr.
  - DRAIN: rden = 0 and addresses hold. Wait until the pipeline is empty (no valid in flight, last pool_valid issued), then go to DONE.
  - DONE: done = 1 for exactly one cycle, busy drops in the same cycle, then IDLE. start in DONE is ignored; start in the following IDLE cycle is accepted.
- Pipeline:
  - A phase-tagged valid bit is delayed RD_LATENCY cycles to align with q.
  - Phase-0 return: m0[k] = signed max(qa[k], qb[k]) is registered.
  - Phase-1 return: pool_data_all[k] <= signed max(m0[k], max(qa[k], qb[k])), with pool_valid <= 1 and pool_addr <= running output counter.
  - Ties select either operand; the value is identical.
- Latency: phase-0 issue at cycle t gives pool_valid at cycle t+RD_LATENCY+2. Throughput is 1 output per 2 cycles, with no bubbles inside a map.
- Output count is exactly (IN_ROWS/2)*(IN_COLS/2) per start. pool_addr goes 0..N-1 in order.
- Outputs hold their last value when pool_valid = 0. pool_valid is a single-cycle pulse per pixel.
- No backpressure: the consumer must accept a word every second cycle.
- Reset mid-operation: immediate abort. No done pulse, no further pool_valid, and upstream memory contents are untouched.

Optional Feature:
- Macro POOL_RELU_CLAMP_EN.
- Defined: each lane's final pooled value is clamped to 0 if negative before it is registered into pool_data_all, at the same latency.
- Undefined: the signed max is passed through unchanged; negative values appear as-is.

Test Plan:
- 4x4 map (IN_ROWS = IN_COLS = 4, RD_LATENCY = 2) with lane0 values 0..15 row-major; start pulse -> 4 outputs, lane0 = 5, 7, 13, 15 at pool_addr 0..3. First pool_valid 4 cycles after the first rden; done 1 cycle after the last valid.
- Lane1 all negative (-100..-85) -> without the macro, lane1 = -95, -93, -87, -85. With POOL_RELU_CLAMP_EN, lane1 = 0 for all outputs while lane0 is unchanged.
- Address check, 24x24 default: first four read pairs are (a, b) = (0, 24), (1, 25), (2, 26), (3, 27). pr = 1 starts at (48, 72); the last issued pair is (551, 575); 144 pool_valid pulses; wren_a/b are 0 throughout.
- Start re-pulsed while busy (cycles 5 and 50) -> ignored. Output count stays 144 with a single done pulse. A start in the IDLE cycle after done launches a second full pass.
- Reset asserted asynchronously mid-READ (after 20 outputs) -> all outputs 0 within the same cycle, no done. A subsequent start yields a full 144-output pass starting from pool_addr 0.
- RD_LATENCY = 1 and 3 builds on the 4x4 map -> same data, first pool_valid 3 and 5 cycles after the first rden respectively.
